// File: rtl/switch_counter_pkg.sv
// Shared types for the switch-controlled board counter.
package switch_counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/switch_counter_tick_gen.sv
// Programmable prescaler: a one-cycle registered tick every DIV clk_2 cycles.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk_2,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  // clr restarts the period so the first tick after it lands DIV edges later
  always_comb begin
    pre_d  = pre_q + PW'(1);
    tick_d = 1'b0;
    if (clr) begin
      pre_d = '0;
    end else if (pre_q == LAST) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/switch_counter.sv
// Board counter with hold/up/down/load modes, advanced by prescaler tick or a
// synchronised step button; wraps or saturates at its limits.
module switch_counter
  import switch_counter_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int DIV      = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [NBITS-1:0] load_val,
  input  logic             use_step,
  input  logic             step,
  output logic [NBITS-1:0] count,
  output logic             tick,
  output logic             limit
);

  if (DIV < 1) begin : g_bad_div
    $error("switch_counter: DIV must be >= 1");
  end
  if (NBITS < 2) begin : g_bad_nbits
    $error("switch_counter: NBITS must be >= 2");
  end

  localparam logic [NBITS-1:0] MAX = '1;

  mode_t            modeSel;
  logic             tickPulse;
  logic             s1_q, s2_q, sq_q;
  logic             stepRise;
  logic             advance;
  logic [NBITS-1:0] count_q, count_d;
  logic             limit_q, limit_d;

  assign modeSel = mode_t'(mode);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_2 (clk_2),
    .reset (reset),
    .clr   (modeSel == MODE_LOAD),
    .tick  (tickPulse)
  );

  // Two flops for metastability, a third to find the rising edge of the button
  always_ff @(posedge clk_2) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      sq_q <= 1'b0;
    end else begin
      s1_q <= step;
      s2_q <= s1_q;
      sq_q <= s2_q;
    end
  end

  assign stepRise = s2_q & ~sq_q;
  assign advance  = use_step ? stepRise : tickPulse;

  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    unique case (modeSel)
      MODE_UP: begin
        if (advance) begin
          if (count_q == MAX) begin
            limit_d = 1'b1;
            count_d = (SATURATE != 0) ? MAX : '0;
          end else begin
            count_d = count_q + NBITS'(1);
          end
        end
      end
      MODE_DOWN: begin
        if (advance) begin
          if (count_q == '0) begin
            limit_d = 1'b1;
            count_d = (SATURATE != 0) ? '0 : MAX;
          end else begin
            count_d = count_q - NBITS'(1);
          end
        end
      end
      MODE_LOAD: count_d = load_val;
      default:   count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign count = count_q;
  assign tick  = tickPulse;
  assign limit = limit_q;

endmodule

// File: tb/tb_switch_counter.sv
// Self-checking bench: two counter configurations share stimulus and are
// compared against a reference model, a vector table and hand-written corner cases.
module tb_switch_counter;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] loadVal;
  logic       useStep;
  logic       step;
  logic [3:0] countA;
  logic       tickA, limitA;
  logic [7:0] countB;
  logic       tickB, limitB;

  int total = 0;
  int bad   = 0;

  // Reference model: per-instance config and state, plus shared step sample history
  int nbM[2]  = '{4, 8};
  int divM[2] = '{1, 4};
  int satM[2] = '{0, 1};
  int mCount[2];
  int mTick[2];
  int mLim[2];
  int mEdges[2];
  bit stepHist[3];

  typedef struct {
    bit         r;
    logic [1:0] m;
    int         expCount;
    int         expTick;
    int         expLimit;
  } vec_t;

  vec_t vecs[13];

  always #5 clk_2 = ~clk_2;

  switch_counter #(.NBITS(4), .DIV(1), .SATURATE(0)) dutA (
    .clk_2    (clk_2),
    .reset    (reset),
    .mode     (mode),
    .load_val (loadVal[3:0]),
    .use_step (useStep),
    .step     (step),
    .count    (countA),
    .tick     (tickA),
    .limit    (limitA)
  );

  switch_counter #(.NBITS(8), .DIV(4), .SATURATE(1)) dutB (
    .clk_2    (clk_2),
    .reset    (reset),
    .mode     (mode),
    .load_val (loadVal),
    .use_step (useStep),
    .step     (step),
    .count    (countB),
    .tick     (tickB),
    .limit    (limitB)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelEdge();
    bit rise;
    int maxV;
    int adv;
    rise = stepHist[1] & ~stepHist[0];
    for (int i = 0; i < 2; i++) begin
      maxV = (1 << nbM[i]) - 1;
      adv  = useStep ? int'(rise) : mTick[i];
      if (reset) begin
        mCount[i] = 0;
        mTick[i]  = 0;
        mLim[i]   = 0;
        mEdges[i] = 0;
      end else begin
        mLim[i] = 0;
        if (mode == UP && adv != 0) begin
          if (mCount[i] == maxV) begin
            mLim[i]   = 1;
            mCount[i] = satM[i] ? maxV : 0;
          end else mCount[i]++;
        end else if (mode == DOWN && adv != 0) begin
          if (mCount[i] == 0) begin
            mLim[i]   = 1;
            mCount[i] = satM[i] ? 0 : maxV;
          end else mCount[i]--;
        end else if (mode == LOAD) begin
          mCount[i] = int'(loadVal) & maxV;
        end
        if (mode == LOAD) begin
          mEdges[i] = 0;
          mTick[i]  = 0;
        end else begin
          mEdges[i]++;
          mTick[i] = (mEdges[i] % divM[i] == 0) ? 1 : 0;
        end
      end
    end
    if (reset) begin
      stepHist = '{0, 0, 0};
    end else begin
      stepHist[0] = stepHist[1];
      stepHist[1] = stepHist[2];
      stepHist[2] = step;
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [1:0] m, input logic [7:0] lv,
                               input bit us, input bit st);
    reset   = r;
    mode    = m;
    loadVal = lv;
    useStep = us;
    step    = st;
    @(posedge clk_2);
    modelEdge();
    #1;
    checkOutput("A.count", int'(countA), mCount[0]);
    checkOutput("A.tick",  int'(tickA),  mTick[0]);
    checkOutput("A.limit", int'(limitA), mLim[0]);
    checkOutput("B.count", int'(countB), mCount[1]);
    checkOutput("B.tick",  int'(tickB),  mTick[1]);
    checkOutput("B.limit", int'(limitB), mLim[1]);
  endtask

  initial begin
    int um;
    bit us;
    bit st;
    logic [1:0] m;

    vecs[0]  = '{1'b1, UP,   0,  0, 0};
    vecs[1]  = '{1'b0, UP,   0,  1, 0};
    vecs[2]  = '{1'b0, UP,   1,  1, 0};
    vecs[3]  = '{1'b0, UP,   2,  1, 0};
    vecs[4]  = '{1'b0, LOAD, 14, 0, 0};
    vecs[5]  = '{1'b0, UP,   14, 1, 0};
    vecs[6]  = '{1'b0, UP,   15, 1, 0};
    vecs[7]  = '{1'b0, UP,   0,  1, 1};
    vecs[8]  = '{1'b0, UP,   1,  1, 0};
    vecs[9]  = '{1'b0, HOLD, 1,  1, 0};
    vecs[10] = '{1'b0, DOWN, 0,  1, 0};
    vecs[11] = '{1'b0, DOWN, 15, 1, 1};
    vecs[12] = '{1'b0, DOWN, 14, 1, 0};

    $display("[TB] vector table on 4-bit wrapping counter");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].r, vecs[i].m, 8'hAE, 1'b0, 1'b0);
      checkOutput("vec.count", int'(countA), vecs[i].expCount);
      checkOutput("vec.tick",  int'(tickA),  vecs[i].expTick);
      checkOutput("vec.limit", int'(limitA), vecs[i].expLimit);
    end

    $display("[TB] full up wrap and prescaler first change");
    applyStimulus(1'b1, UP, 8'h00, 1'b0, 1'b0);
    for (int e = 1; e <= 18; e++) begin
      applyStimulus(1'b0, UP, 8'h00, 1'b0, 1'b0);
      if (e == 4) checkOutput("pre.before", int'(countB), 0);
      if (e == 4) checkOutput("pre.tick4", int'(tickB), 1);
      if (e == 5) checkOutput("pre.first", int'(countB), 1);
      if (e == 16) checkOutput("wrap.max", int'(countA), 15);
      if (e == 17) checkOutput("wrap.zero", int'(countA), 0);
      if (e == 17) checkOutput("wrap.limit", int'(limitA), 1);
    end

    $display("[TB] load restart");
    applyStimulus(1'b0, LOAD, 8'hA5, 1'b0, 1'b0);
    checkOutput("load.count", int'(countB), 8'hA5);
    checkOutput("load.tick", int'(tickB), 0);
    checkOutput("load.limit", int'(limitB), 0);
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(1'b0, UP, 8'h00, 1'b0, 1'b0);
      if (e == 4) checkOutput("load.hold4", int'(countB), 8'hA5);
      if (e == 5) checkOutput("load.next", int'(countB), 8'hA6);
    end

    $display("[TB] down saturate");
    applyStimulus(1'b0, LOAD, 8'h02, 1'b0, 1'b0);
    for (int e = 1; e <= 17; e++) begin
      applyStimulus(1'b0, DOWN, 8'h00, 1'b0, 1'b0);
      if (e == 9) checkOutput("sat.zero", int'(countB), 0);
      if (e == 13 || e == 17) begin
        checkOutput("sat.stay", int'(countB), 0);
        checkOutput("sat.limit", int'(limitB), 1);
      end
    end

    $display("[TB] step button");
    applyStimulus(1'b1, UP, 8'h00, 1'b1, 1'b0);
    for (int press = 0; press < 2; press++) begin
      for (int e = 1; e <= 20; e++) begin
        applyStimulus(1'b0, UP, 8'h00, 1'b1, 1'b1);
        if (e == 2) checkOutput("step.lat2", int'(countB), press);
        if (e == 3) checkOutput("step.lat3", int'(countB), press + 1);
      end
      checkOutput("step.once", int'(countB), press + 1);
      for (int e = 0; e < 6; e++) applyStimulus(1'b0, UP, 8'h00, 1'b1, 1'b0);
    end

    $display("[TB] reset mid-count");
    applyStimulus(1'b1, UP, 8'h00, 1'b0, 1'b0);
    for (int e = 1; e <= 40; e++) applyStimulus(1'b0, UP, 8'h00, 1'b0, 1'b0);
    checkOutput("mid.count9", int'(countB), 9);
    checkOutput("mid.tick", int'(tickB), 1);
    applyStimulus(1'b1, UP, 8'hFF, 1'b0, 1'b0);
    checkOutput("rst.count", int'(countB), 0);
    checkOutput("rst.tick", int'(tickB), 0);
    checkOutput("rst.limit", int'(limitB), 0);
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(1'b0, UP, 8'h00, 1'b0, 1'b0);
      if (e == 4) checkOutput("resume.wait", int'(countB), 0);
      if (e == 5) checkOutput("resume.first", int'(countB), 1);
    end

    $display("[TB] randomized run");
    us = 1'b0;
    st = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      um = $urandom_range(0, 9);
      if (um == 0) m = HOLD;
      else if (um <= 4) m = UP;
      else if (um <= 8) m = DOWN;
      else m = LOAD;
      if ($urandom_range(0, 49) == 0) us = ~us;
      if ($urandom_range(0, 7) == 0) st = ~st;
      applyStimulus($urandom_range(0, 99) == 0, m, 8'($urandom), us, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
